demux_1to2: RTL and testbench

Buffered 1:2 stream demultiplexer for the elements catalog, the inverse of the 2:1 mux: one n-bit input stream is steered by `sel` to one of two output channels. Each output channel has its own 2-entry FIFO with a valid/ready handshake, so a stalled consumer on one channel does not block traffic to the other. The block sits between a single producer and two independent consumers, for example to split a datapath result between two destination units.

---
 rtl/demux_1to2.sv | 150 +++++++++++++++
 tb/tb_demux_1to2.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2.sv
// Buffered 1:2 stream demultiplexer: one valid/ready input steered by sel into
// two independent 2-entry FIFOs, so a stalled consumer never blocks the other channel.

// Per-channel 2-entry FIFO; the occupancy count is the FSM state.
//   state | meaning
//   EMPTY | no words stored, q_valid=0, head forced to 0
//   ONE   | one word stored at rd_ptr
//   TWO   | both entries used, push refused upstream
module demux_1to2_fifo #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [n-1:0] wdata,
    input  logic         pop,
    output logic [n-1:0] rdata,
    output logic         valid,
    output logic         full
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e               state_q, state_d;
    logic [1:0][n-1:0]  mem_q, mem_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [n-1:0]       rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && (state_q != TWO);
        do_pop   = pop && (state_q != EMPTY);

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            EMPTY: if (do_push) state_d = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_d = TWO;
                else if (do_pop && !do_push) state_d = EMPTY;
            end
            TWO:     if (do_pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        // Outputs are registered from next-state so the head is visible right after the push edge.
        valid_d = (state_d != EMPTY);
        full_d  = (state_d == TWO);
        rdata_d = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign full  = full_q;

endmodule

module demux_1to2 #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sel,
    input  logic [n-1:0] d,
    input  logic         d_valid,
    output logic         d_ready,
    output logic [n-1:0] q0,
    output logic         q0_valid,
    input  logic         q0_ready,
    output logic [n-1:0] q1,
    output logic         q1_valid,
    input  logic         q1_ready
);

    logic full0;
    logic full1;
    logic dest_full;
    logic xfer;
    logic push0;
    logic push1;

    // Only the selected channel's registered fullness gates acceptance; no path from q*_ready.
    assign dest_full = sel ? full1 : full0;
    assign d_ready   = en && !dest_full;
    assign xfer      = d_valid && d_ready;
    assign push0     = xfer && !sel;
    assign push1     = xfer && sel;

    demux_1to2_fifo #(.n(n)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (d),
        .pop   (q0_ready),
        .rdata (q0),
        .valid (q0_valid),
        .full  (full0)
    );

    demux_1to2_fifo #(.n(n)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (d),
        .pop   (q1_ready),
        .rdata (q1),
        .valid (q1_valid),
        .full  (full1)
    );

endmodule

// File: tb/tb_demux_1to2.sv
// Scoreboard bench for demux_1to2: directed pushes queue expected words per channel,
// a negedge monitor pops and compares whenever a channel hands a word to its consumer.
module tb_demux_1to2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sel;
    logic [7:0] d;
    logic       d_valid;
    logic       d_ready;
    logic [7:0] q0;
    logic       q0_valid;
    logic       q0_ready;
    logic [7:0] q1;
    logic       q1_valid;
    logic       q1_ready;

    int checks   = 0;
    int failures = 0;
    int pops1    = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    demux_1to2 #(.n(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .q0       (q0),
        .q0_valid (q0_valid),
        .q0_ready (q0_ready),
        .q1       (q1),
        .q1_valid (q1_valid),
        .q1_ready (q1_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic s, input logic [7:0] data);
        sel     = s;
        d       = data;
        d_valid = 1'b1;
        @(negedge clk);
        check("d_ready_on_push", {31'd0, d_ready}, 32'd1);
        if (d_ready) begin
            if (s) exp1.push_back(data);
            else   exp0.push_back(data);
        end
        step();
        d_valid = 1'b0;
    endtask

    // Monitor: a pop happens at the next posedge when valid&ready are seen here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q0_valid && q0_ready) begin
                if (exp0.size() == 0) check("q0_unexpected_word", {24'd0, q0}, 32'hFFFF_FFFF);
                else                  check("q0_data_order", {24'd0, q0}, {24'd0, exp0.pop_front()});
            end
            if (q1_valid && q1_ready) begin
                pops1++;
                if (exp1.size() == 0) check("q1_unexpected_word", {24'd0, q1}, 32'hFFFF_FFFF);
                else                  check("q1_data_order", {24'd0, q1}, {24'd0, exp1.pop_front()});
            end
            if (!q0_valid) check("q0_zero_when_empty", {24'd0, q0}, 32'd0);
            if (!q1_valid) check("q1_zero_when_empty", {24'd0, q1}, 32'd0);
        end
    end

    initial begin
        int pops_before;
        rst_n    = 1'b0;
        en       = 1'b1;
        sel      = 1'b0;
        d        = 8'h00;
        d_valid  = 1'b0;
        q0_ready = 1'b0;
        q1_ready = 1'b0;

        // Reset then idle
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_q0_valid", {31'd0, q0_valid}, 32'd0);
        check("rst_q1_valid", {31'd0, q1_valid}, 32'd0);
        check("rst_q0", {24'd0, q0}, 32'd0);
        check("rst_q1", {24'd0, q1}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd1);
        step();

        // Steering
        push_word(1'b0, 8'hA5);
        @(negedge clk);
        check("steer_q0_valid", {31'd0, q0_valid}, 32'd1);
        check("steer_q0", {24'd0, q0}, 32'hA5);
        check("steer_q1_idle", {31'd0, q1_valid}, 32'd0);
        step();
        push_word(1'b1, 8'h3C);
        @(negedge clk);
        check("steer_q1_valid", {31'd0, q1_valid}, 32'd1);
        check("steer_q1", {24'd0, q1}, 32'h3C);
        step();
        q0_ready = 1'b1;
        q1_ready = 1'b1;
        step();
        q0_ready = 1'b0;
        q1_ready = 1'b0;
        @(negedge clk);
        check("steer_drained_q0", {31'd0, q0_valid}, 32'd0);
        check("steer_drained_q1", {31'd0, q1_valid}, 32'd0);
        step();

        // Full / backpressure on channel 0 only
        push_word(1'b0, 8'h11);
        push_word(1'b0, 8'h22);
        sel     = 1'b0;
        d       = 8'hEE;
        d_valid = 1'b1;
        #1;
        check("full_sel0_d_ready", {31'd0, d_ready}, 32'd0);
        sel = 1'b1;
        #1;
        check("full_sel1_d_ready", {31'd0, d_ready}, 32'd1);
        d_valid = 1'b0;
        sel     = 1'b0;
        q0_ready = 1'b1;
        step();
        step();
        q0_ready = 1'b0;
        @(negedge clk);
        check("full_drained_q0", {31'd0, q0_valid}, 32'd0);
        step();

        // Simultaneous push/pop on channel 1, then streaming
        push_word(1'b1, 8'h01);
        q1_ready = 1'b1;
        push_word(1'b1, 8'h02);
        q1_ready = 1'b0;
        @(negedge clk);
        check("pushpop_q1_valid", {31'd0, q1_valid}, 32'd1);
        check("pushpop_q1", {24'd0, q1}, 32'h02);
        sel     = 1'b0;
        d_valid = 1'b1;
        #1;
        check("pushpop_ch0_not_full", {31'd0, d_ready}, 32'd1);
        d_valid = 1'b0;
        step();
        pops_before = pops1;
        q1_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(1'b1, 8'(i));
        step();
        step();
        q1_ready = 1'b0;
        check("stream_pop_count", 32'(pops1 - pops_before), 32'd17);
        check("stream_q1_empty", {31'd0, q1_valid}, 32'd0);
        check("stream_exp1_empty", 32'(exp1.size()), 32'd0);

        // Enable gating
        push_word(1'b0, 8'h44);
        en      = 1'b0;
        sel     = 1'b0;
        d       = 8'h99;
        d_valid = 1'b1;
        @(negedge clk);
        check("en0_d_ready_sel0", {31'd0, d_ready}, 32'd0);
        step();
        sel = 1'b1;
        @(negedge clk);
        check("en0_d_ready_sel1", {31'd0, d_ready}, 32'd0);
        step();
        d_valid  = 1'b0;
        q0_ready = 1'b1;
        step();
        step();
        q0_ready = 1'b0;
        @(negedge clk);
        check("en0_q0_drained", {31'd0, q0_valid}, 32'd0);
        check("en0_q1_no_push", {31'd0, q1_valid}, 32'd0);
        en = 1'b1;
        step();

        // Reset mid-operation with both channels full
        push_word(1'b0, 8'h55);
        push_word(1'b0, 8'h66);
        push_word(1'b1, 8'h77);
        push_word(1'b1, 8'h88);
        sel = 1'b1;
        #1;
        check("midrst_full1_d_ready", {31'd0, d_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        exp0.delete();
        exp1.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_q0_valid", {31'd0, q0_valid}, 32'd0);
        check("midrst_q1_valid", {31'd0, q1_valid}, 32'd0);
        check("midrst_q0", {24'd0, q0}, 32'd0);
        check("midrst_q1", {24'd0, q1}, 32'd0);
        check("midrst_d_ready", {31'd0, d_ready}, 32'd1);
        step();
        push_word(1'b1, 8'hAB);
        @(negedge clk);
        check("midrst_single_q1_valid", {31'd0, q1_valid}, 32'd1);
        check("midrst_single_q1", {24'd0, q1}, 32'hAB);
        check("midrst_single_q0_valid", {31'd0, q0_valid}, 32'd0);
        q1_ready = 1'b1;
        step();
        q1_ready = 1'b0;
        @(negedge clk);
        check("midrst_single_alone", {31'd0, q1_valid}, 32'd0);
        step();

        check("end_exp0_empty", 32'(exp0.size()), 32'd0);
        check("end_exp1_empty", 32'(exp1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
